// File: rtl/axi_mem_responder_if.sv
// axi_channel: AXI4 bus bundle shared by the responder and its bench
interface axi_channel #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input logic clk,
    input logic rstn
);
    logic                    aw_valid, aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    w_valid, w_ready, w_last;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_valid, b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    ar_valid, ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    r_valid, r_ready, r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic [USER_WIDTH-1:0]   r_user;

    modport master (
        input  clk, rstn, aw_ready, w_ready, b_valid, b_id, b_resp, b_user,
               ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user,
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
               w_valid, w_data, w_strb, w_last, b_ready,
               ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready
    );

    modport slave (
        input  clk, rstn, aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
               w_valid, w_data, w_strb, w_last, b_ready,
               ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp, b_user,
               ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave that serialises one burst at a time into word memory accesses
module axi_mem_responder #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_channel.slave                 master,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH/8-1:0]   mem_wmask,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    localparam int OFFS = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_t;

    state_t                state_q, state_d;
    logic                  last_rd_q, last_rd_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr, step, incr, wrap_mask;
    logic [7:0]            len_q, len_d, cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [8:0]            iss_q, iss_d;
    logic                  bad_q, bad_d, err_q, err_d, pending_q, pending_d;
    logic                  grant_w, issue;

    function automatic logic burst_bad(input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
        return b == 2'b11 || s > 3'(OFFS) ||
               (b == 2'b10 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
    endfunction

    assign mem_addr  = MEM_ADDR_WIDTH'(addr_q >> OFFS);
    assign mem_wmask = master.w_strb;
    assign mem_wdata = master.w_data;

    // Address of the beat after the current one for FIXED, INCR and WRAP bursts
    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        incr      = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        next_addr = burst_q == 2'b00 ? addr_q :
                    burst_q == 2'b10 ? (addr_q & ~wrap_mask) | (incr & wrap_mask) : incr;
    end

    // Burst FSM: arbitration, beat sequencing and channel outputs
    always_comb begin
        state_d         = state_q;
        last_rd_d       = last_rd_q;
        id_d            = id_q;
        addr_d          = addr_q;
        len_d           = len_q;
        size_d          = size_q;
        burst_d         = burst_q;
        cnt_d           = cnt_q;
        iss_d           = iss_q;
        bad_d           = bad_q;
        err_d           = err_q;
        pending_d       = pending_q;
        master.aw_ready = 1'b0;
        master.ar_ready = 1'b0;
        master.w_ready  = 1'b0;
        master.b_valid  = 1'b0;
        master.b_id     = id_q;
        master.b_resp   = 2'b00;
        master.b_user   = '0;
        master.r_valid  = 1'b0;
        master.r_id     = id_q;
        master.r_data   = '0;
        master.r_resp   = 2'b00;
        master.r_last   = 1'b0;
        master.r_user   = '0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        grant_w         = master.aw_valid && (!master.ar_valid || last_rd_q);
        issue           = iss_q != 9'd0 && (!pending_q || master.r_ready);
        case (state_q)
            IDLE: begin
                master.aw_ready = grant_w;
                master.ar_ready = master.ar_valid && !grant_w;
                if (grant_w) begin
                    state_d   = WRITE;
                    last_rd_d = 1'b0;
                    id_d      = master.aw_id;
                    addr_d    = master.aw_addr;
                    len_d     = master.aw_len;
                    size_d    = master.aw_size;
                    burst_d   = master.aw_burst;
                    cnt_d     = master.aw_len;
                    bad_d     = burst_bad(master.aw_burst, master.aw_size, master.aw_len);
                    err_d     = bad_d;
                end else if (master.ar_valid) begin
                    state_d   = READ;
                    last_rd_d = 1'b1;
                    id_d      = master.ar_id;
                    addr_d    = master.ar_addr;
                    len_d     = master.ar_len;
                    size_d    = master.ar_size;
                    burst_d   = master.ar_burst;
                    cnt_d     = master.ar_len;
                    iss_d     = {1'b0, master.ar_len} + 9'd1;
                    bad_d     = burst_bad(master.ar_burst, master.ar_size, master.ar_len);
                    err_d     = bad_d;
                    pending_d = 1'b0;
                end
            end
            WRITE: begin
                master.w_ready = 1'b1;
                if (master.w_valid) begin
                    mem_req = !bad_q;
                    mem_we  = 1'b1;
                    addr_d  = next_addr;
                    cnt_d   = cnt_q - 8'd1;
                    err_d   = err_q || (master.w_last != (cnt_q == 8'd0));
                    state_d = cnt_q == 8'd0 ? WRITE_RESP : WRITE;
                end
            end
            WRITE_RESP: begin
                master.b_valid = 1'b1;
                master.b_resp  = err_q ? 2'b10 : 2'b00;
                state_d        = master.b_ready ? IDLE : WRITE_RESP;
            end
            READ: begin
                mem_req        = issue && !bad_q;
                master.r_valid = pending_q;
                master.r_data  = bad_q ? '0 : mem_rdata;
                master.r_resp  = bad_q ? 2'b10 : 2'b00;
                master.r_last  = cnt_q == 8'd0;
                addr_d         = issue ? next_addr : addr_q;
                iss_d          = issue ? iss_q - 9'd1 : iss_q;
                pending_d      = issue || (pending_q && !master.r_ready);
                if (pending_q && master.r_ready) begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = cnt_q == 8'd0 ? IDLE : READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset that abandons any burst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            iss_q     <= '0;
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            iss_q     <= iss_d;
            bad_q     <= bad_d;
            err_q     <= err_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed stimulus with queue scoreboard for the AXI memory responder
module tb_axi_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rstn;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_stall = 1'b0;

    typedef struct {logic we; logic [15:0] addr; logic [7:0] mask; logic [63:0] data;} mem_t;
    typedef struct {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_t;
    typedef struct {logic [3:0] id; logic [1:0] resp;} b_t;

    mem_t exp_mem[$];
    r_t   exp_r[$];
    b_t   exp_b[$];

    assign rstn = !rst;
    always #5 clk = !clk;

    axi_channel #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .USER_WIDTH(1)) bus (.clk(clk), .rstn(rstn));

    axi_mem_responder #(.MEM_ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .master(bus), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] rd(input logic [15:0] a);
        return {16'hDA7A, 32'h0, a};
    endfunction

    always @(posedge clk) if (mem_req && !mem_we) mem_rdata <= rd(mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a memory access or a response
    always @(negedge clk) begin
        mem_t m;
        r_t   r;
        b_t   b;
        if (rst) prev_stall = 1'b0;
        else begin
            if (prev_stall) chk("r_valid_held", bus.r_valid, 1);
            if (mem_req) begin
                if (exp_mem.size() == 0) chk("mem_req_unexpected", mem_req, 0);
                else begin
                    m = exp_mem.pop_front();
                    chk("mem_we", mem_we, m.we);
                    chk("mem_addr", mem_addr, m.addr);
                    if (m.we) begin
                        chk("mem_wmask", mem_wmask, m.mask);
                        chk("mem_wdata", mem_wdata, m.data);
                    end
                end
            end
            if (bus.b_valid && bus.b_ready) begin
                if (exp_b.size() == 0) chk("b_unexpected", bus.b_valid, 0);
                else begin
                    b = exp_b.pop_front();
                    chk("b_id", bus.b_id, b.id);
                    chk("b_resp", bus.b_resp, b.resp);
                end
            end
            if (bus.r_valid && !bus.r_ready && exp_r.size() != 0) chk("r_data_stalled", bus.r_data, exp_r[0].data);
            if (bus.r_valid && bus.r_ready) begin
                if (exp_r.size() == 0) chk("r_unexpected", bus.r_valid, 0);
                else begin
                    r = exp_r.pop_front();
                    chk("r_id", bus.r_id, r.id);
                    chk("r_data", bus.r_data, r.data);
                    chk("r_resp", bus.r_resp, r.resp);
                    chk("r_last", bus.r_last, r.last);
                end
            end
            prev_stall = bus.r_valid && !bus.r_ready;
        end
    end

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok = 1'b0;
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst;
        bus.aw_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.aw_ready) begin ok = 1'b1; break; end
        end
        chk("aw_handshake", ok, 1);
        @(posedge clk);
        #1 bus.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok = 1'b0;
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size; bus.ar_burst = burst;
        bus.ar_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ar_ready) begin ok = 1'b1; break; end
        end
        chk("ar_handshake", ok, 1);
        @(posedge clk);
        #1 bus.ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        logic ok = 1'b0;
        bus.w_data = data; bus.w_strb = strb; bus.w_last = last; bus.w_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.w_ready) begin ok = 1'b1; break; end
        end
        chk("w_handshake", ok, 1);
        @(posedge clk);
        #1 bus.w_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_mem.size() + exp_r.size() + exp_b.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(exp_mem.size() + exp_r.size() + exp_b.size()), 0);
        exp_mem.delete(); exp_r.delete(); exp_b.delete();
    endtask

    task automatic check_idle_outputs();
        chk("idle_aw_ready", bus.aw_ready, 0);
        chk("idle_ar_ready", bus.ar_ready, 0);
        chk("idle_w_ready", bus.w_ready, 0);
        chk("idle_b_valid", bus.b_valid, 0);
        chk("idle_r_valid", bus.r_valid, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        logic [63:0] wd [4] = '{64'hCAFE_0000_0000_0000, 64'hCAFE_0000_0000_0001,
                                64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0003};
        logic [7:0]  ws [4] = '{8'hFF, 8'h0F, 8'hF0, 8'h3C};
        bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
        bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0;
        bus.b_ready = 1; bus.r_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs();

        // Contention right after reset: read first, then write
        exp_mem.push_back('{0, 16'h1, 8'h0, 64'h0});
        exp_mem.push_back('{0, 16'h2, 8'h0, 64'h0});
        exp_mem.push_back('{1, 16'h20, 8'hFF, 64'h1111});
        exp_r.push_back('{4'd1, rd(16'h1), 2'b00, 1'b0});
        exp_r.push_back('{4'd1, rd(16'h2), 2'b00, 1'b1});
        exp_b.push_back('{4'd2, 2'b00});
        @(posedge clk); #1;
        fork
            send_ar(4'd1, 32'h8, 8'd1, 3'd3, 2'b01);
            begin
                send_aw(4'd2, 32'h100, 8'd0, 3'd3, 2'b01);
                send_w(64'h1111, 8'hFF, 1'b1);
            end
        join
        wait_drain();

        // Write INCR, 4 beats
        for (int i = 0; i < 4; i++) exp_mem.push_back('{1, 16'(2 + i), ws[i], wd[i]});
        exp_b.push_back('{4'd5, 2'b00});
        send_aw(4'd5, 32'h10, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) send_w(wd[i], ws[i], i == 3);
        wait_drain();

        // Read WRAP with r_ready toggling
        exp_mem.push_back('{0, 16'h3, 8'h0, 64'h0});
        exp_mem.push_back('{0, 16'h0, 8'h0, 64'h0});
        exp_mem.push_back('{0, 16'h1, 8'h0, 64'h0});
        exp_mem.push_back('{0, 16'h2, 8'h0, 64'h0});
        exp_r.push_back('{4'd3, rd(16'h3), 2'b00, 1'b0});
        exp_r.push_back('{4'd3, rd(16'h0), 2'b00, 1'b0});
        exp_r.push_back('{4'd3, rd(16'h1), 2'b00, 1'b0});
        exp_r.push_back('{4'd3, rd(16'h2), 2'b00, 1'b1});
        fork
            send_ar(4'd3, 32'h18, 8'd3, 3'd3, 2'b10);
            begin
                repeat (24) begin @(posedge clk); #1 bus.r_ready = !bus.r_ready; end
                bus.r_ready = 1'b1;
            end
        join
        wait_drain();

        // Reserved burst type read: SLVERR beats with zero data, no memory access
        exp_r.push_back('{4'd7, 64'h0, 2'b10, 1'b0});
        exp_r.push_back('{4'd7, 64'h0, 2'b10, 1'b1});
        send_ar(4'd7, 32'h40, 8'd1, 3'd3, 2'b11);
        wait_drain();

        // Early w_last on a 3-beat write
        for (int i = 0; i < 3; i++) exp_mem.push_back('{1, 16'(4 + i), 8'hFF, wd[i]});
        exp_b.push_back('{4'd6, 2'b10});
        send_aw(4'd6, 32'h20, 8'd2, 3'd3, 2'b01);
        for (int i = 0; i < 3; i++) send_w(wd[i], 8'hFF, i != 1);
        wait_drain();

        // Reset while a read is stalled
        bus.r_ready = 1'b0;
        exp_mem.push_back('{0, 16'h0, 8'h0, 64'h0});
        send_ar(4'd4, 32'h0, 8'd7, 3'd3, 2'b01);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs();
        bus.r_ready = 1'b1;
        repeat (5) @(posedge clk);
        chk("rst_no_extra_mem", 64'(exp_mem.size()), 0);
        #1;
        exp_mem.push_back('{0, 16'h6, 8'h0, 64'h0});
        exp_r.push_back('{4'd9, rd(16'h6), 2'b00, 1'b1});
        send_ar(4'd9, 32'h30, 8'd0, 3'd3, 2'b01);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default 16, memory word-address width.
REQ-002 clk  input  1  clock; all logic is on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 master  axi_channel.slave  -  AXI4 responder port; widths come from the interface; interface clk/rstn are unused.
REQ-005 mem_req  output  1  memory access strobe, one word per cycle.
REQ-006 mem_we  output  1  1 = write, 0 = read.
REQ-007 mem_addr  output  MEM_ADDR_WIDTH  word address: byte address >> log2(DATA_WIDTH/8), upper bits truncated.
REQ-008 mem_wmask  output  DATA_WIDTH/8  byte enables (w_strb).
REQ-009 mem_wdata  output  DATA_WIDTH  write data (w_data).
REQ-010 mem_rdata  input  DATA_WIDTH  read data.
- Valid one cycle after a read mem_req.
- Held stable while mem_req is low.

Function
REQ-011 FSM states: IDLE, WRITE, WRITE_RESP, READ.
- Only one burst is in flight at a time.
- aw_ready and ar_ready are asserted only in IDLE.
REQ-012 IDLE arbitration:
- Only aw_valid or only ar_valid: that request is granted.
- Both valid: grant the type not granted last.
- last_grant resets to WRITE, so the first contention goes to read.
- Only the granted ready is high; a handshake latches id, addr, len, size, burst.
REQ-013 A burst is in error when any of these holds:
- burst == 2'b11;
- size > log2(DATA_WIDTH/8);
- WRAP with len not in {1,3,7,15}.
An errored burst performs no memory access.
REQ-014 Address update after each beat:
- FIXED: unchanged.
- INCR: (addr aligned to 2^size) + 2^size.
- WRAP: as INCR, but wraps within a region aligned to (len+1)*2^size.
REQ-015 Beat counter is 8 bits; it loads len and counts down to 0 on the final beat.
REQ-016 WRITE state:
- w_ready = 1.
- Each w handshake drives mem_req = 1, mem_we = 1 and mem_addr/mem_wmask/mem_wdata combinationally in the same cycle (mem_req = 0 for an errored burst).
- The final counted beat moves to WRITE_RESP.
REQ-017 w_last handling:
- Asserted early, or missing on the final counted beat: latch SLVERR.
- The beat counter alone decides the burst end.
REQ-018 WRITE_RESP:
- b_valid = 1; b_id = latched id; b_user = 0.
- b_resp = OKAY (2'b00), or SLVERR (2'b10) if an error was latched.
- On b handshake, go to IDLE.
REQ-019 READ state, issue side:
- mem_req = 1 and mem_we = 0 when beats remain to issue and (pending == 0 or r_ready == 1).
- pending is set the cycle after an issue and cleared on an r handshake with no new issue.
REQ-020 READ state, R channel:
- r_valid = pending; r_data = mem_rdata.
- r_id = latched id; r_resp = OKAY; r_user = 0.
- r_last = 1 on the final beat.
- Read latency is 1 cycle; full throughput is one beat per cycle while r_ready = 1.
REQ-021 Errored read: return len+1 beats with r_data = 0, r_resp = SLVERR and r_last on the final beat; mem_req stays 0.
REQ-022 After the r_last handshake, go to IDLE the next cycle.
REQ-023 r_valid must not drop without a handshake, and r_data must stay stable while stalled.

Reset
REQ-024 While rst = 1, at the next edge:
- state = IDLE; last_grant = WRITE; pending = 0; error flag = 0.
- All ready/valid outputs and mem_req are 0.
REQ-025 Reset mid-burst abandons the burst: no B or R is issued afterwards, and no further mem_req occurs.

Verification
REQ-026 Write INCR: AW addr 0x10, len 3, size 3 (DATA_WIDTH 64), 4 W beats.
- Expect mem_addr 2,3,4,5 with mem_we = 1.
- Expect one B with OKAY and matching id.
REQ-027 Read WRAP: AR addr 0x18, len 3, size 3.
- Expect mem_addr 3,0,1,2.
- Expect 4 R beats with r_last only on the 4th; r_ready toggled 1/0 shows data held while stalled.
REQ-028 Simultaneous aw_valid and ar_valid after reset: read granted first, then the write, with no overlap.
REQ-029 Error cases:
- burst = 2'b11, len 1 read: 2 R beats with SLVERR, data 0, no mem_req.
- w_last on beat 1 of a len-2 write: B SLVERR after 3 beats.
REQ-030 Reset in the middle of a READ:
- All outputs are 0 next cycle.
- A new AR is accepted afterwards and completes with OKAY.
